// File: rtl/layer_src_mux.sv
// Sequenced N-way source selector for the neuron list: walks NLAYER layers of NWORDS
// words, picking the external input stream for layer 0 and activation feedback after.
module layer_src_mux #(
  parameter int DWIDTH = 32,
  parameter int NSRC   = 2,
  parameter int NLAYER = 3,
  parameter int NWORDS = 16,
  localparam int SELW  = (NSRC > 2) ? $clog2(NSRC) : 1,
  localparam int LW    = (NLAYER > 2) ? $clog2(NLAYER) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     mode,
  input  logic [SELW-1:0]          man_sel,
  input  logic [NSRC*DWIDTH-1:0]   in_data,
  input  logic [NSRC-1:0]          in_valid,
  output logic [NSRC-1:0]          in_ready,
  output logic signed [DWIDTH-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LW-1:0]            layer_idx,
  output logic [SELW-1:0]          sel_cur,
  output logic                     busy,
  output logic                     done
);

  localparam int CW = (NWORDS > 2) ? $clog2(NWORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                   state_reg;
  logic [CW-1:0]            cnt_reg;
  logic [LW-1:0]            layer_reg;
  logic [SELW-1:0]          sel_reg;
  logic                     mode_reg;
  logic [SELW-1:0]          man_reg;
  logic signed [DWIDTH-1:0] out_data_reg;
  logic                     out_valid_reg;
  logic                     done_reg;

  logic signed [DWIDTH-1:0] src_word [NSRC];
  logic                     run_ok;
  logic                     accept;
  logic                     last_word;
  logic                     last_layer;
  logic [SELW-1:0]          sel_next;

  function automatic logic [SELW-1:0] clamp_sel(input logic [SELW-1:0] s);
    if (int'(s) > NSRC - 1)
      return SELW'(NSRC - 1);
    return s;
  endfunction

  function automatic logic [SELW-1:0] auto_sel(input int l);
    if (l > NSRC - 1)
      return SELW'(NSRC - 1);
    return SELW'(l);
  endfunction

  // The output register may only take a new word if it is empty or draining this cycle.
  assign run_ok = (state_reg == RUN) && (!out_valid_reg || out_ready);

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    assign src_word[gi] = in_data[gi*DWIDTH +: DWIDTH];
    assign in_ready[gi] = run_ok && (sel_reg == SELW'(gi));
  end

  // in_ready is one-hot on the selected source, so this is the selected handshake.
  assign accept     = |(in_valid & in_ready);
  assign last_word  = (int'(cnt_reg) == NWORDS - 1);
  assign last_layer = (int'(layer_reg) == NLAYER - 1);
  assign sel_next   = mode_reg ? man_reg : auto_sel(int'(layer_reg) + 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      layer_reg     <= '0;
      sel_reg       <= '0;
      mode_reg      <= 1'b0;
      man_reg       <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;

      if (accept) begin
        out_data_reg  <= src_word[sel_reg];
        out_valid_reg <= 1'b1;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= RUN;
            mode_reg  <= mode;
            man_reg   <= clamp_sel(man_sel);
            layer_reg <= '0;
            cnt_reg   <= '0;
            sel_reg   <= mode ? clamp_sel(man_sel) : '0;
          end
        end
        RUN: begin
          if (accept) begin
            if (last_word) begin
              cnt_reg <= '0;
              if (last_layer) begin
                state_reg <= DRAIN;
              end else begin
                layer_reg <= layer_reg + 1'b1;
                sel_reg   <= sel_next;
              end
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (!out_valid_reg || out_ready) begin
            done_reg  <= 1'b1;
            state_reg <= IDLE;
            layer_reg <= '0;
            sel_reg   <= '0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign layer_idx = layer_reg;
  assign sel_cur   = sel_reg;
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;

endmodule

// File: tb/tb_layer_src_mux.sv
// Scoreboard bench for layer_src_mux: three instances (2-, 3- and 4-source) share clk/rst_n;
// the driver pushes expected words on each accept and a forked monitor pops on each output handshake.
module tb_layer_src_mux;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance: NSRC=2, NLAYER=3, NWORDS=4
  logic        start, mode, man_sel;
  logic [63:0] in_data;
  logic [1:0]  in_valid, in_ready;
  logic signed [31:0] out_data;
  logic        out_valid, out_ready;
  logic [1:0]  layer_idx;
  logic        sel_cur, busy, done;

  // Clamp instance: NSRC=3, NLAYER=2, NWORDS=2
  logic        start3, mode3;
  logic [1:0]  man_sel3;
  logic [95:0] in_data3;
  logic [2:0]  in_valid3, in_ready3;
  logic signed [31:0] out_data3;
  logic        out_valid3, out_ready3;
  logic [0:0]  layer_idx3;
  logic [1:0]  sel_cur3;
  logic        busy3, done3;

  // Sequencing instance: NSRC=4, NLAYER=5, NWORDS=1
  logic         start4, mode4;
  logic [1:0]   man_sel4;
  logic [127:0] in_data4;
  logic [3:0]   in_valid4, in_ready4;
  logic signed [31:0] out_data4;
  logic         out_valid4, out_ready4;
  logic [2:0]   layer_idx4;
  logic [1:0]   sel_cur4;
  logic         busy4, done4;

  layer_src_mux #(.DWIDTH(32), .NSRC(2), .NLAYER(3), .NWORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .man_sel(man_sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .layer_idx(layer_idx), .sel_cur(sel_cur), .busy(busy), .done(done)
  );

  layer_src_mux #(.DWIDTH(32), .NSRC(3), .NLAYER(2), .NWORDS(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .mode(mode3), .man_sel(man_sel3),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .layer_idx(layer_idx3), .sel_cur(sel_cur3), .busy(busy3), .done(done3)
  );

  layer_src_mux #(.DWIDTH(32), .NSRC(4), .NLAYER(5), .NWORDS(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode4), .man_sel(man_sel4),
    .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
    .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready4),
    .layer_idx(layer_idx4), .sel_cur(sel_cur4), .busy(busy4), .done(done4)
  );

  logic [31:0] exp_q[$];
  logic [31:0] q3[$];
  logic [31:0] q4[$];
  logic [31:0] mon_e;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int done3_cnt = 0;
  int done4_cnt = 0;
  int words_seen = 0;
  bit mon_man = 1'b0;
  bit rdy0_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic extra_word(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=%0h required=no_word", name, act);
  endtask

  // Entered and left at posedge+1.
  task automatic start_frame(input logic m, input logic s);
    mode = m;
    man_sel = s;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_word(input int src, input logic [31:0] data, input int exp_sel,
                           input int exp_layer);
    bit got;
    got = 1'b0;
    in_data[src*32 +: 32] = data;
    in_valid[src] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready[src]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      chk("accept_timeout", 32'(in_ready), 32'(1 << src));
    end else begin
      exp_q.push_back(data);
      chk("sel_cur", 32'(sel_cur), 32'(exp_sel));
      chk("layer_idx", 32'(layer_idx), 32'(exp_layer));
    end
    @(posedge clk);
    #1 in_valid[src] = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy && !busy3 && !busy4) begin
        idle = 1'b1;
        break;
      end
    end
    if (!idle) chk(name, 32'({busy, busy3, busy4}), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_auto();
    done_cnt = 0;
    start_frame(1'b0, 1'b0);
    for (int k = 0; k < 4; k++) send_word(0, 32'(k + 1), 0, 0);
    for (int k = 0; k < 8; k++) send_word(1, 32'(-(5 + k)), 1, (k / 4) + 1);
    wait_idle("auto_idle_timeout");
    chk("auto_done_count", 32'(done_cnt), 32'd1);
    chk("auto_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("auto_layer_after", 32'(layer_idx), 32'd0);
  endtask

  initial begin
    start = 0; mode = 0; man_sel = 0; in_data = '0; in_valid = '0; out_ready = 1'b1;
    start3 = 0; mode3 = 0; man_sel3 = '0; in_data3 = '0; in_valid3 = '0; out_ready3 = 1'b1;
    start4 = 0; mode4 = 0; man_sel4 = '0; in_data4 = '0; in_valid4 = '0; out_ready4 = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (out_valid === 1'b1 && out_ready) begin
          words_seen++;
          $display("word %0d main out_data=%0d", words_seen, out_data);
          if (exp_q.size() == 0) extra_word("main_extra_word", out_data);
          else begin
            mon_e = exp_q.pop_front();
            chk("main_out_data", out_data, mon_e);
          end
        end
        if (out_valid3 === 1'b1 && out_ready3) begin
          $display("word src3 out_data=%0d", out_data3);
          if (q3.size() == 0) extra_word("dut3_extra_word", out_data3);
          else begin
            mon_e = q3.pop_front();
            chk("dut3_out_data", out_data3, mon_e);
          end
        end
        if (out_valid4 === 1'b1 && out_ready4) begin
          $display("word src4 out_data=%0d", out_data4);
          if (q4.size() == 0) extra_word("dut4_extra_word", out_data4);
          else begin
            mon_e = q4.pop_front();
            chk("dut4_out_data", out_data4, mon_e);
          end
        end
        if (done === 1'b1) done_cnt++;
        if (done3 === 1'b1) done3_cnt++;
        if (done4 === 1'b1) done4_cnt++;
        if (mon_man && in_ready[0]) rdy0_seen = 1'b1;
      end
      begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_layer_idx", 32'(layer_idx), 32'd0);
    chk("rst_sel_cur", 32'(sel_cur), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Auto frame at full throughput
    run_auto();

    // Backpressure: hold 0x7FFFFFFF for three cycles
    done_cnt = 0;
    start_frame(1'b0, 1'b0);
    send_word(0, 32'h7FFF_FFFF, 0, 0);
    out_ready = 1'b0;
    in_data[31:0] = 32'd2;
    in_valid[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("hold_out_data", out_data, 32'h7FFF_FFFF);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready0", 32'(in_ready[0]), 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    for (int k = 2; k <= 4; k++) send_word(0, 32'(k), 0, 0);
    for (int k = 0; k < 8; k++) send_word(1, 32'(100 + k), 1, (k / 4) + 1);
    wait_idle("bp_idle_timeout");
    chk("bp_done_count", 32'(done_cnt), 32'd1);
    chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Manual mode on source 1
    done_cnt = 0;
    rdy0_seen = 1'b0;
    mon_man = 1'b1;
    start_frame(1'b1, 1'b1);
    for (int k = 0; k < 12; k++) send_word(1, 32'(200 + k), 1, k / 4);
    wait_idle("man_idle_timeout");
    mon_man = 1'b0;
    chk("man_in_ready0_seen", 32'(rdy0_seen), 32'd0);
    chk("man_done_count", 32'(done_cnt), 32'd1);
    chk("man_queue_empty", 32'(exp_q.size()), 32'd0);

    // Start while busy at word 6 must be ignored
    done_cnt = 0;
    start_frame(1'b0, 1'b0);
    for (int k = 0; k < 4; k++) send_word(0, 32'(300 + k), 0, 0);
    for (int k = 0; k < 2; k++) send_word(1, 32'(400 + k), 1, 1);
    start_frame(1'b1, 1'b0);
    mode = 1'b0;
    for (int k = 2; k < 8; k++) send_word(1, 32'(400 + k), 1, (k / 4) + 1);
    wait_idle("busy_idle_timeout");
    chk("busy_done_count", 32'(done_cnt), 32'd1);

    // Reset mid-frame with a held word
    done_cnt = 0;
    start_frame(1'b0, 1'b0);
    send_word(0, 32'd55, 0, 0);
    out_ready = 1'b0;
    @(negedge clk);
    chk("mid_pre_out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_layer_idx", 32'(layer_idx), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    chk("mid_rst_done_count", 32'(done_cnt), 32'd0);
    run_auto();

    // NSRC=3: man_sel=3 clamps to source 2; sources 0 and 1 chatter throughout
    done3_cnt = 0;
    in_data3 = {32'd33, 32'd22, 32'd11};
    in_valid3 = 3'b111;
    for (int k = 0; k < 4; k++) q3.push_back(32'd33);
    mode3 = 1'b1;
    man_sel3 = 2'd3;
    start3 = 1'b1;
    @(posedge clk);
    #1 start3 = 1'b0;
    @(negedge clk);
    chk("clamp_sel_cur", 32'(sel_cur3), 32'd2);
    chk("clamp_in_ready", 32'(in_ready3), 32'b100);
    wait_idle("clamp_idle_timeout");
    in_valid3 = '0;
    chk("clamp_done_count", 32'(done3_cnt), 32'd1);
    chk("clamp_queue_empty", 32'(q3.size()), 32'd0);

    // NSRC=4, NLAYER=5, NWORDS=1 auto: source order 0,1,2,3,3
    done4_cnt = 0;
    in_data4 = {32'd103, 32'd102, 32'd101, 32'd100};
    in_valid4 = 4'hF;
    q4.push_back(32'd100);
    q4.push_back(32'd101);
    q4.push_back(32'd102);
    q4.push_back(32'd103);
    q4.push_back(32'd103);
    mode4 = 1'b0;
    start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    wait_idle("seq_idle_timeout");
    in_valid4 = '0;
    chk("seq_done_count", 32'(done4_cnt), 32'd1);
    chk("seq_queue_empty", 32'(q4.size()), 32'd0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
